// File: rtl/mem_responder.sv
// mem_responder: 256x16 memory slave with a req/ack handshake and access counter.
// Define MEM_WAIT_EN to insert WAIT_CYCLES wait states before every response.
module mem_responder #(
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        MemRW,
    input  logic [7:0]  MemAddr,
    input  logic [15:0] MemD,
    output logic [15:0] MemQ,
    output logic        ack,
    output logic        busy,
    output logic [15:0] acc_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
`ifdef MEM_WAIT_EN
        WAIT = 2'd1,
`endif
        RESP = 2'd2
    } state_t;

    if (WAIT_CYCLES < 1 || WAIT_CYCLES > 3) begin : g_bad_wait_cycles
        $error("mem_responder: WAIT_CYCLES must be 1..3");
    end

    state_t      state_q, state_d;
    logic [15:0] mem_q [256];
    logic [15:0] memq_q, memq_d;
    logic [15:0] cnt_q, cnt_d;
    logic        acc_rw;
    logic [7:0]  acc_addr;
    logic [15:0] acc_data;
    logic        resp_entry;

`ifdef MEM_WAIT_EN
    localparam logic [1:0] WAIT_LOAD = 2'(WAIT_CYCLES - 1);

    logic        rw_q;
    logic [7:0]  addr_q;
    logic [15:0] data_q;
    logic [1:0]  wcnt_q, wcnt_d;

    // Latch the request in IDLE and hold it for the rest of the access
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rw_q   <= 1'b0;
            addr_q <= 8'h00;
            data_q <= 16'h0000;
        end else if (state_q == IDLE && req) begin
            rw_q   <= MemRW;
            addr_q <= MemAddr;
            data_q <= MemD;
        end
    end

    // Wait-state down-counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) wcnt_q <= 2'd0;
        else      wcnt_q <= wcnt_d;
    end

    assign acc_rw   = rw_q;
    assign acc_addr = addr_q;
    assign acc_data = data_q;
`else
    // Capture and RESP entry fall on the same edge, so the live inputs are used
    assign acc_rw   = MemRW;
    assign acc_addr = MemAddr;
    assign acc_data = MemD;
`endif

    // Next-state logic for the access sequencer
    always_comb begin
        state_d = state_q;
`ifdef MEM_WAIT_EN
        wcnt_d  = wcnt_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (req) begin
`ifdef MEM_WAIT_EN
                    state_d = WAIT;
                    wcnt_d  = WAIT_LOAD;
`else
                    state_d = RESP;
`endif
                end
            end
`ifdef MEM_WAIT_EN
            WAIT: begin
                if (wcnt_q == 2'd0) state_d = RESP;
                else                wcnt_d  = wcnt_q - 2'd1;
            end
`endif
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign resp_entry = (state_d == RESP) && (state_q != RESP);

    // Response data and saturating access counter
    always_comb begin
        memq_d = memq_q;
        cnt_d  = cnt_q;
        if (resp_entry) memq_d = acc_rw ? acc_data : mem_q[acc_addr];
        if (state_q == RESP && cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
    end

    // State, read-data and counter registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            memq_q  <= 16'h0000;
            cnt_q   <= 16'h0000;
        end else begin
            state_q <= state_d;
            memq_q  <= memq_d;
            cnt_q   <= cnt_d;
        end
    end

    // Storage array: not reset, written only on RESP entry of a write
    always_ff @(posedge clk) begin
        if (rst && resp_entry && acc_rw) mem_q[acc_addr] <= acc_data;
    end

    assign MemQ    = memq_q;
    assign ack     = (state_q == RESP);
    assign busy    = (state_q != IDLE);
    assign acc_cnt = cnt_q;

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: table vectors, reset/saturation sequences and random traffic
// checked against a memory/counter model of mem_responder.
module tb_mem_responder;

    localparam int WC = 2;
`ifdef MEM_WAIT_EN
    localparam int WAITS = WC;
`else
    localparam int WAITS = 0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req = 1'b0;
    logic        MemRW = 1'b0;
    logic [7:0]  MemAddr = 8'h00;
    logic [15:0] MemD = 16'h0000;
    logic [15:0] MemQ;
    logic        ack;
    logic        busy;
    logic [15:0] acc_cnt;

    int tests = 0;
    int failed = 0;

    logic [15:0] model_mem [256];
    bit          known [256];
    int          exp_cnt;

    typedef struct {
        logic        rw;
        logic [7:0]  addr;
        logic [15:0] data;
        logic [15:0] exp_q;
    } vec_t;

    mem_responder #(.WAIT_CYCLES(WC)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .MemRW   (MemRW),
        .MemAddr (MemAddr),
        .MemD    (MemD),
        .MemQ    (MemQ),
        .ack     (ack),
        .busy    (busy),
        .acc_cnt (acc_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] got,
                         input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic access(input logic rw, input logic [7:0] a,
                          input logic [15:0] d, input bit scramble,
                          output logic [15:0] got);
        logic [15:0] exp;
        int lat;
        int nbusy;
        exp = rw ? d : model_mem[a];
        @(negedge clk);
        req = 1'b1; MemRW = rw; MemAddr = a; MemD = d;
        @(posedge clk);
        #1;
        req = 1'b0;
        lat = 0;
        nbusy = 0;
        while (lat < 12) begin
            if (scramble) begin
                req     = 1'($urandom);
                MemRW   = 1'($urandom);
                MemAddr = 8'($urandom);
                MemD    = 16'($urandom);
            end
            @(negedge clk);
            lat++;
            if (busy) nbusy++;
            if (ack) break;
        end
        req = 1'b0;
        got = MemQ;
        check("latency", 32'(lat), 32'(1 + WAITS));
        check("busy_cycles", 32'(nbusy), 32'(1 + WAITS));
        check("memq", 32'(MemQ), 32'(exp));
        if (rw) begin
            model_mem[a] = d;
            known[a] = 1'b1;
        end
        if (exp_cnt < 16'hFFFF) exp_cnt++;
        @(negedge clk);
        check("idle_ack", 32'(ack), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
        check("acc_cnt", 32'(acc_cnt), 32'(exp_cnt));
        check("memq_hold", 32'(MemQ), 32'(exp));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] got;
        logic [7:0]  addrs [8];
        vec_t        vecs [8];

        for (int i = 0; i < 256; i++) begin
            known[i] = 1'b0;
            model_mem[i] = 16'h0000;
        end
        exp_cnt = 0;

        addrs = '{8'h00, 8'h01, 8'h10, 8'h20, 8'h7F, 8'h80, 8'hFE, 8'hFF};

        vecs[0] = '{1'b1, 8'h10, 16'hBEEF, 16'hBEEF};
        vecs[1] = '{1'b0, 8'h10, 16'h0000, 16'hBEEF};
        vecs[2] = '{1'b1, 8'hFF, 16'h1234, 16'h1234};
        vecs[3] = '{1'b0, 8'hFF, 16'hFFFF, 16'h1234};
        vecs[4] = '{1'b1, 8'h00, 16'h0000, 16'h0000};
        vecs[5] = '{1'b1, 8'h01, 16'hFFFF, 16'hFFFF};
        vecs[6] = '{1'b0, 8'h00, 16'h5A5A, 16'h0000};
        vecs[7] = '{1'b0, 8'h01, 16'h0000, 16'hFFFF};

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_memq", 32'(MemQ), 32'h0000);
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_acc_cnt", 32'(acc_cnt), 32'h0000);
        rst = 1'b1;

        // Table-driven vectors
        for (int i = 0; i < 8; i++) begin
            access(vecs[i].rw, vecs[i].addr, vecs[i].data, 1'b0, got);
            check($sformatf("vec%0d_q", i), 32'(got), 32'(vecs[i].exp_q));
        end

        // Reset in the middle of a write to 0x20
        access(1'b1, 8'h20, 16'h5555, 1'b0, got);
        @(negedge clk);
        req = 1'b1; MemRW = 1'b1; MemAddr = 8'h20; MemD = 16'hAAAA;
        @(posedge clk);
        #1;
        req = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        check("midrst_memq", 32'(MemQ), 32'h0000);
        check("midrst_ack", 32'(ack), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_cnt", 32'(acc_cnt), 32'h0000);
`ifndef MEM_WAIT_EN
        model_mem[8'h20] = 16'hAAAA;
`endif
        exp_cnt = 0;
        @(negedge clk);
        check("midrst_memq_held", 32'(MemQ), 32'h0000);
        @(posedge clk);
        #1;
        rst = 1'b1;
        check("postrst_memq", 32'(MemQ), 32'h0000);
        access(1'b0, 8'h20, 16'h0000, 1'b0, got);
`ifdef MEM_WAIT_EN
        check("abort_keeps_old", 32'(got), 32'h5555);
`else
        check("resp_write_kept", 32'(got), 32'hAAAA);
`endif
        check("postrst_cnt", 32'(acc_cnt), 32'd1);

        // Random traffic, inputs scrambled while busy
        for (int i = 0; i < 40; i++) begin
            logic [7:0] a;
            logic       rw;
            a  = addrs[$urandom_range(0, 7)];
            rw = !known[a] || ($urandom_range(0, 1) == 1);
            access(rw, a, 16'($urandom), 1'b1, got);
        end

        // Counter saturation from a preloaded value
        @(negedge clk);
        force dut.cnt_q = 16'hFFFE;
        #1;
        release dut.cnt_q;
        #1;
        exp_cnt = 16'hFFFE;
        check("preload_cnt", 32'(acc_cnt), 32'h0000FFFE);
        for (int i = 0; i < 3; i++) begin
            access(1'b1, 8'h40 + 8'(i), 16'hC000 + 16'(i), 1'b0, got);
        end
        check("sat_cnt", 32'(acc_cnt), 32'h0000FFFF);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
